// File: rtl/cnn_layer_accel_ce_macc_array.sv
// Multi-lane signed multiply-accumulate array for CNN convolution windows.
// Three-stage pipeline (operand, product, accumulate) with per-lane overflow tracking.
module cnn_layer_accel_ce_macc_array #(
  parameter int C_NUM_LANES = 4,
  parameter int C_A_WIDTH   = 16,
  parameter int C_B_WIDTH   = 16,
  parameter int C_ACC_WIDTH = 48,
  parameter int C_CNT_WIDTH = 10,
  parameter int C_SATURATE  = 1
) (
  input  logic                               CLK,
  input  logic                               rst_n,
  input  logic [C_CNT_WIDTH-1:0]             cfg_kernel_len,
  input  logic [1:0]                         cfg_mode,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [C_NUM_LANES*C_A_WIDTH-1:0]   A,
  input  logic [C_NUM_LANES*C_B_WIDTH-1:0]   B,
  input  logic [C_NUM_LANES*C_ACC_WIDTH-1:0] C,
  input  logic [C_NUM_LANES*C_ACC_WIDTH-1:0] P_IN,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [C_NUM_LANES*C_ACC_WIDTH-1:0] P,
  output logic [C_NUM_LANES-1:0]             ovf,
  output logic                               busy
);

  localparam int AW = C_A_WIDTH;
  localparam int BW = C_B_WIDTH;
  localparam int PW = C_A_WIDTH + C_B_WIDTH;
  localparam int W  = C_ACC_WIDTH;

  function automatic logic sum_ovf(input logic signed [W:0] s);
    return s[W] != s[W-1];
  endfunction

  function automatic logic signed [W-1:0] sum_clip(input logic signed [W:0] s);
    if (s[W] == s[W-1] || C_SATURATE == 0)
      return s[W-1:0];
    else if (s[W])
      return {1'b1, {(W-1){1'b0}}};
    else
      return {1'b0, {(W-1){1'b1}}};
  endfunction

  logic                   stall, accept, beat_first, beat_last;
  logic [C_CNT_WIDTH-1:0] cnt, len_q, len_eff;
  logic                   vld_p0, first_p0, last_p0;
  logic                   vld_p1, first_p1, last_p1;

  // A pending, unaccepted result freezes the whole array.
  assign stall      = out_valid && !out_ready;
  assign in_ready   = !stall;
  assign accept     = in_valid && in_ready;
  assign len_eff    = (cfg_kernel_len == '0) ? C_CNT_WIDTH'(1) : cfg_kernel_len;
  assign beat_first = (cnt == '0);
  assign beat_last  = beat_first ? (len_eff == C_CNT_WIDTH'(1))
                                 : (cnt == len_q - C_CNT_WIDTH'(1));
  assign busy       = (cnt != '0) || vld_p0 || vld_p1;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      len_q     <= C_CNT_WIDTH'(1);
      vld_p0    <= 1'b0;
      first_p0  <= 1'b0;
      last_p0   <= 1'b0;
      vld_p1    <= 1'b0;
      first_p1  <= 1'b0;
      last_p1   <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      // stage 0: beat capture and window counter
      vld_p0   <= accept;
      first_p0 <= accept && beat_first;
      last_p0  <= accept && beat_last;
      if (accept) begin
        cnt <= beat_last ? '0 : cnt + C_CNT_WIDTH'(1);
        if (beat_first)
          len_q <= len_eff;
      end
      // stage 1: product
      vld_p1   <= vld_p0;
      first_p1 <= first_p0;
      last_p1  <= last_p0;
      // stage 2: accumulate / result
      if (vld_p1 && last_p1)
        out_valid <= 1'b1;
      else
        out_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < C_NUM_LANES; g++) begin : g_lane
    logic signed [AW-1:0] a_p0;
    logic signed [BW-1:0] b_p0;
    logic signed [W-1:0]  init_p0, init_p1, prod_p1, acc_p2, p_q;
    logic signed [W-1:0]  init_sel, base;
    logic signed [PW-1:0] prod;
    logic signed [W:0]    sum;
    logic                 ovf_p2, ovf_q, win_ovf;

    always_comb begin
      case (cfg_mode)
        2'd1:    init_sel = C[g*W +: W];
        2'd2:    init_sel = P_IN[g*W +: W];
        default: init_sel = '0;
      endcase
    end

    assign prod    = a_p0 * b_p0;
    assign base    = first_p1 ? init_p1 : acc_p2;
    assign sum     = (W+1)'(base) + (W+1)'(prod_p1);
    // Overflow is sticky across the window and restarts on beat 0.
    assign win_ovf = sum_ovf(sum) || (!first_p1 && ovf_p2);

    always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
        a_p0    <= '0;
        b_p0    <= '0;
        init_p0 <= '0;
        init_p1 <= '0;
        prod_p1 <= '0;
        acc_p2  <= '0;
        ovf_p2  <= 1'b0;
        p_q     <= '0;
        ovf_q   <= 1'b0;
      end else if (!stall) begin
        if (accept) begin
          a_p0 <= A[g*AW +: AW];
          b_p0 <= B[g*BW +: BW];
          if (beat_first)
            init_p0 <= init_sel;
        end
        if (vld_p0) begin
          prod_p1 <= W'(prod);
          init_p1 <= init_p0;
        end
        if (vld_p1) begin
          acc_p2 <= sum_clip(sum);
          ovf_p2 <= win_ovf;
          if (last_p1) begin
            p_q   <= sum_clip(sum);
            ovf_q <= win_ovf;
          end
        end
      end
    end

    assign P[g*W +: W] = p_q;
    assign ovf[g]      = ovf_q;
  end

endmodule

// File: tb/tb_cnn_layer_accel_ce_macc_array.sv
// Directed bench for the MACC array: default 48-bit instance plus 32-bit
// saturating and wrapping instances sharing the same stimulus.
module tb_cnn_layer_accel_ce_macc_array;

  localparam int NL = 4;
  localparam int AW = 16;
  localparam int W  = 48;
  localparam int WS = 32;
  localparam int CW = 10;

  logic           CLK = 1'b0;
  logic           rst_n;
  logic [CW-1:0]  cfg_kernel_len;
  logic [1:0]     cfg_mode;
  logic           in_valid, out_ready;
  logic [NL*AW-1:0] A, B;
  logic [NL*W-1:0]  C, P_IN;
  logic [NL*WS-1:0] c32, pin32;

  logic             in_ready, out_valid, busy;
  logic [NL*W-1:0]  P;
  logic [NL-1:0]    ovf;
  logic             in_ready_s, out_valid_s, busy_s;
  logic [NL*WS-1:0] P_s;
  logic [NL-1:0]    ovf_s;
  logic             in_ready_w, out_valid_w, busy_w;
  logic [NL*WS-1:0] P_w;
  logic [NL-1:0]    ovf_w;

  cnn_layer_accel_ce_macc_array u_dut (
    .CLK(CLK), .rst_n(rst_n), .cfg_kernel_len(cfg_kernel_len), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .C(C), .P_IN(P_IN),
    .out_valid(out_valid), .out_ready(out_ready), .P(P), .ovf(ovf), .busy(busy));

  cnn_layer_accel_ce_macc_array #(.C_ACC_WIDTH(WS), .C_SATURATE(1)) u_sat (
    .CLK(CLK), .rst_n(rst_n), .cfg_kernel_len(cfg_kernel_len), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_ready(in_ready_s), .A(A), .B(B), .C(c32), .P_IN(pin32),
    .out_valid(out_valid_s), .out_ready(out_ready), .P(P_s), .ovf(ovf_s), .busy(busy_s));

  cnn_layer_accel_ce_macc_array #(.C_ACC_WIDTH(WS), .C_SATURATE(0)) u_wrap (
    .CLK(CLK), .rst_n(rst_n), .cfg_kernel_len(cfg_kernel_len), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_ready(in_ready_w), .A(A), .B(B), .C(c32), .P_IN(pin32),
    .out_valid(out_valid_w), .out_ready(out_ready), .P(P_w), .ovf(ovf_w), .busy(busy_w));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [NL*W-1:0]  p;
    logic [NL*WS-1:0] ps, pw;
    logic [NL-1:0]    ov, ovs, ovw;
    int               cyc;
  } rec_t;
  rec_t q[$];

  always @(negedge CLK) begin
    rec_t r;
    if (rst_n && out_valid && out_ready) begin
      r.p = P; r.ps = P_s; r.pw = P_w;
      r.ov = ovf; r.ovs = ovf_s; r.ovw = ovf_w;
      r.cyc = cyc;
      q.push_back(r);
    end
  end

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  function automatic logic [63:0] lane48(input logic [NL*W-1:0] v, input int k);
    logic signed [W-1:0] t;
    t = v[k*W +: W];
    return 64'(t);
  endfunction

  function automatic logic [63:0] lane32(input logic [NL*WS-1:0] v, input int k);
    return 64'(v[k*WS +: WS]);
  endfunction

  task automatic send(input logic [NL*AW-1:0] a, input logic [NL*AW-1:0] b);
    int n = 0;
    A = a; B = b; in_valid = 1'b1;
    @(negedge CLK);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge CLK);
    end
    chk("send_ready", 64'(in_ready), 64'd1);
    @(posedge CLK); #1;
  endtask

  task automatic wait_q(input string tag, input int n);
    for (int i = 0; i < 60 && q.size() < n; i++) @(negedge CLK);
    chk(tag, 64'(q.size()), 64'(n));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", err_cnt);
    $fatal(1);
  end

  initial begin
    rec_t r;
    int c0, n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_kernel_len = '0; cfg_mode = 2'd0;
    A = '0; B = '0; C = '0; P_IN = '0; c32 = '0; pin32 = '0;

    // reset state
    repeat (3) @(negedge CLK);
    chk("rst_P", 64'(P != '0), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge CLK); #1; rst_n = 1'b1;
    repeat (2) @(posedge CLK); #1;

    // L=3, mode 0: 2*5+3*5+4*5 = 45, visible three cycles after the last beat
    q.delete();
    cfg_kernel_len = 10'd3; cfg_mode = 2'd0;
    send(pk(2, 0, 0, 0), pk(5, 0, 0, 0));
    send(pk(3, 0, 0, 0), pk(5, 0, 0, 0));
    send(pk(4, 0, 0, 0), pk(5, 0, 0, 0));
    in_valid = 1'b0;
    @(negedge CLK);
    chk("l3_ov_t1", 64'(out_valid), 64'd0);
    chk("l3_busy_t1", 64'(busy), 64'd1);
    @(negedge CLK);
    chk("l3_ov_t2", 64'(out_valid), 64'd0);
    @(negedge CLK);
    chk("l3_ov_t3", 64'(out_valid), 64'd1);
    chk("l3_P0", lane48(P, 0), 64'd45);
    chk("l3_P1", lane48(P, 1), 64'd0);
    chk("l3_ovf", 64'(ovf), 64'd0);
    @(negedge CLK);
    chk("l3_ov_done", 64'(out_valid), 64'd0);
    chk("l3_busy_done", 64'(busy), 64'd0);
    @(posedge CLK); #1;

    // L=2 mode 1 on lane 1: -12+14+100 = 102; then mode 2: 12+0-50 = -38
    // with cfg changed mid-window (must be ignored)
    q.delete();
    C = '0; P_IN = '0;
    C[W +: W] = 48'(100);
    P_IN[W +: W] = 48'(-50);
    cfg_kernel_len = 10'd2; cfg_mode = 2'd1;
    send(pk(0, -3, 0, 0), pk(0, 4, 0, 0));
    send(pk(0, 7, 0, 0), pk(0, 2, 0, 0));
    cfg_mode = 2'd2;
    send(pk(0, -3, 0, 0), pk(0, -4, 0, 0));
    cfg_mode = 2'd1; cfg_kernel_len = 10'd5;
    send(pk(0, 7, 0, 0), pk(0, 0, 0, 0));
    in_valid = 1'b0;
    wait_q("bias_cnt", 2);
    if (q.size() >= 2) begin
      r = q.pop_front();
      chk("bias_P1", lane48(r.p, 1), 64'd102);
      chk("bias_P0", lane48(r.p, 0), 64'd0);
      r = q.pop_front();
      chk("casc_P1", lane48(r.p, 1), -64'sd38);
    end
    C = '0; P_IN = '0;
    repeat (3) @(posedge CLK); #1;
    chk("casc_no_extra", 64'(q.size()), 64'd0);

    // L=1 (and L=0 treated as 1): one result per beat on consecutive cycles
    q.delete();
    cfg_kernel_len = 10'd1; cfg_mode = 2'd0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) cfg_kernel_len = 10'd0;
      send(pk(i + 1, 0, 0, -(i + 1)), pk(3, 0, 0, 3));
    end
    in_valid = 1'b0;
    wait_q("l1_cnt", 8);
    c0 = (q.size() > 0) ? q[0].cyc : 0;
    n = q.size();
    for (int i = 0; i < 8 && i < n; i++) begin
      r = q[i];
      chk("l1_P0", lane48(r.p, 0), 64'(3 * (i + 1)));
      chk("l1_P3", lane48(r.p, 3), 64'(-3 * (i + 1)));
      chk("l1_cyc", 64'(r.cyc - c0), 64'(i));
    end
    q.delete();
    repeat (2) @(posedge CLK); #1;

    // back-pressure: result held for 5 cycles, no beat lost
    cfg_kernel_len = 10'd1; cfg_mode = 2'd0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(pk(10 * (i + 1), 0, 0, 0), pk(1, 0, 0, 0));
        in_valid = 1'b0;
      end
      begin
        int m;
        m = 0;
        while (!out_valid && m < 50) begin
          m++;
          @(negedge CLK);
        end
        chk("stall_pending", 64'(out_valid), 64'd1);
        repeat (5) begin
          @(negedge CLK);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_P", lane48(P, 0), 64'd10);
        end
        @(posedge CLK); #1;
        out_ready = 1'b1;
      end
    join
    wait_q("stall_cnt", 4);
    n = q.size();
    for (int i = 0; i < 4 && i < n; i++) begin
      r = q[i];
      chk("stall_res", lane48(r.p, 0), 64'(10 * (i + 1)));
    end
    q.delete();
    repeat (2) @(posedge CLK); #1;

    // 32-bit overflow: 3 * 2^30 clamps to 0x7FFFFFFF or wraps to 0xC0000000
    cfg_kernel_len = 10'd3; cfg_mode = 2'd0;
    for (int i = 0; i < 3; i++)
      send(pk(-32768, -32768, -32768, -32768), pk(-32768, -32768, -32768, -32768));
    cfg_kernel_len = 10'd1;
    send(pk(1, 0, 0, 0), pk(1, 0, 0, 0));
    in_valid = 1'b0;
    wait_q("ovf_cnt", 2);
    if (q.size() >= 2) begin
      r = q.pop_front();
      chk("sat_P0", lane32(r.ps, 0), 64'h7FFF_FFFF);
      chk("sat_ovf0", 64'(r.ovs[0]), 64'd1);
      chk("wrap_P0", lane32(r.pw, 0), 64'hC000_0000);
      chk("wrap_ovf0", 64'(r.ovw[0]), 64'd1);
      chk("wide_P0", lane48(r.p, 0), 64'd3221225472);
      chk("wide_ovf", 64'(r.ov), 64'd0);
      r = q.pop_front();
      chk("sat_clr_P0", lane32(r.ps, 0), 64'd1);
      chk("sat_clr_ovf", 64'(r.ovs), 64'd0);
      chk("wrap_clr_ovf", 64'(r.ovw), 64'd0);
    end
    q.delete();
    repeat (2) @(posedge CLK); #1;

    // reset after beat 2 of an L=4 window, then a fresh L=2 window: 3*4+5*6 = 42
    cfg_kernel_len = 10'd4;
    for (int i = 0; i < 3; i++) send(pk(100, 0, 0, 0), pk(1, 0, 0, 0));
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_busy", 64'(busy), 64'd0);
    end
    chk("rst_mid_P", lane48(P, 0), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    @(posedge CLK); #1; rst_n = 1'b1;
    q.delete();
    @(posedge CLK); #1;
    cfg_kernel_len = 10'd2;
    send(pk(3, 0, 0, 0), pk(4, 0, 0, 0));
    send(pk(5, 0, 0, 0), pk(6, 0, 0, 0));
    in_valid = 1'b0;
    wait_q("post_rst_cnt", 1);
    if (q.size() >= 1) begin
      r = q.pop_front();
      chk("post_rst_P0", lane48(r.p, 0), 64'd42);
    end
    repeat (4) @(posedge CLK); #1;
    chk("post_rst_no_extra", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
